// File: rtl/furv_bus_arbiter.sv
// furv_bus_arbiter: two-master, one-slave arbiter for the data-memory bus.
// m0 is the core load/store port, and m1 is a secondary requester such as DMA or debug.
// The grant is registered and handed out round-robin.
// The granted master is routed combinationally to the slave.
// An optional wait counter forces an error ack when the slave stalls too long.
module furv_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_mem,
    input  logic        m0_write,
    input  logic [29:0] m0_addr,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_data_out,
    output logic [31:0] m0_data_in,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_mem,
    input  logic        m1_write,
    input  logic [29:0] m1_addr,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_data_out,
    output logic [31:0] m1_data_in,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        s_mem,
    output logic        s_write,
    output logic [29:0] s_addr,
    output logic [3:0]  s_sel,
    output logic [31:0] s_data_out,
    input  logic [31:0] s_data_in,
    input  logic        s_ack
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
    localparam logic        TO_EN_C   = (TIMEOUT != 0);

    state_t      state_r;
    logic        last_r;   // last master served: 0 = m0, 1 = m1
    logic [15:0] cnt_r;    // grant cycles spent waiting for s_ack

    logic timeout_s;
    logic ack0_s;
    logic ack1_s;

    // A forced completion fires only when the slave is not acking in the same cycle.
    // In that case s_ack wins and no error is flagged.
    assign timeout_s = TO_EN_C && (cnt_r == TIMEOUT_C) && !s_ack;

    // Acks reach only the granted master, and only while it still holds its request.
    // A master that drops its request has aborted, so it receives no ack.
    assign ack0_s = (state_r == ST_GRANT0) && m0_mem && (s_ack || timeout_s);
    assign ack1_s = (state_r == ST_GRANT1) && m1_mem && (s_ack || timeout_s);

    assign m0_ack     = ack0_s;
    assign m1_ack     = ack1_s;
    assign m0_err     = ack0_s && timeout_s;
    assign m1_err     = ack1_s && timeout_s;
    assign m0_data_in = s_data_in;
    assign m1_data_in = s_data_in;

    // Route the granted master to the slave; the slave side is quiet while idle.
    always_comb begin
        s_mem      = 1'b0;
        s_write    = 1'b0;
        s_addr     = 30'd0;
        s_sel      = 4'd0;
        s_data_out = 32'd0;
        case (state_r)
            ST_GRANT0: begin
                s_mem      = m0_mem;
                s_write    = m0_write;
                s_addr     = m0_addr;
                s_sel      = m0_sel;
                s_data_out = m0_data_out;
            end
            ST_GRANT1: begin
                s_mem      = m1_mem;
                s_write    = m1_write;
                s_addr     = m1_addr;
                s_sel      = m1_sel;
                s_data_out = m1_data_out;
            end
            default: begin
                s_mem      = 1'b0;
                s_write    = 1'b0;
                s_addr     = 30'd0;
                s_sel      = 4'd0;
                s_data_out = 32'd0;
            end
        endcase
    end

    // Arbitration FSM: round-robin grant, wait counting, and back-to-back handover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            last_r  <= 1'b1;
            cnt_r   <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 16'd0;
                    if (m0_mem && m1_mem) begin
                        state_r <= last_r ? ST_GRANT0 : ST_GRANT1;
                    end else if (m0_mem) begin
                        state_r <= ST_GRANT0;
                    end else if (m1_mem) begin
                        state_r <= ST_GRANT1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT0: begin
                    if (!m0_mem) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 16'd0;
                    end else if (ack0_s) begin
                        last_r  <= 1'b0;
                        cnt_r   <= 16'd0;
                        state_r <= m1_mem ? ST_GRANT1 : ST_IDLE;
                    end else if (cnt_r != 16'hFFFF) begin
                        cnt_r <= cnt_r + 16'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_GRANT1: begin
                    if (!m1_mem) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 16'd0;
                    end else if (ack1_s) begin
                        last_r  <= 1'b1;
                        cnt_r   <= 16'd0;
                        state_r <= m0_mem ? ST_GRANT0 : ST_IDLE;
                    end else if (cnt_r != 16'hFFFF) begin
                        cnt_r <= cnt_r + 16'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_furv_bus_arbiter.sv
// Directed testbench for furv_bus_arbiter, built with a short slave timeout of 4.
module tb_furv_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_mem, m0_write, m1_mem, m1_write;
    logic [29:0] m0_addr, m1_addr;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_data_out, m1_data_out, m0_data_in, m1_data_in;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_mem, s_write, s_ack;
    logic [29:0] s_addr;
    logic [3:0]  s_sel;
    logic [31:0] s_data_out, s_data_in;

    int n_checks = 0;
    int n_fail   = 0;

    furv_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_mem(m0_mem), .m0_write(m0_write), .m0_addr(m0_addr), .m0_sel(m0_sel),
        .m0_data_out(m0_data_out), .m0_data_in(m0_data_in), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_mem(m1_mem), .m1_write(m1_write), .m1_addr(m1_addr), .m1_sel(m1_sel),
        .m1_data_out(m1_data_out), .m1_data_in(m1_data_in), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_mem(s_mem), .s_write(s_write), .s_addr(s_addr), .s_sel(s_sel),
        .s_data_out(s_data_out), .s_data_in(s_data_in), .s_ack(s_ack)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_mem = 1'b0; m0_write = 1'b0; m0_addr = 30'd0; m0_sel = 4'd0; m0_data_out = 32'd0;
        m1_mem = 1'b0; m1_write = 1'b0; m1_addr = 30'd0; m1_sel = 4'd0; m1_data_out = 32'd0;
        s_ack = 1'b0; s_data_in = 32'd0;
        step(); step();
        n_checks++; if (s_mem !== 1'b0) begin n_fail++; $display("FAIL reset_s_mem got %b exp 0", s_mem); end
        n_checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_acks got %b exp 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
        n_checks++; if ({s_write, s_addr, s_sel, s_data_out} !== 67'd0) begin n_fail++; $display("FAIL reset_s_bus got %h exp 0", {s_write, s_addr, s_sel, s_data_out}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_load();
        m0_mem = 1'b1; m0_write = 1'b0; m0_addr = 30'h0000100; m0_sel = 4'hF;
        #1;
        n_checks++; if (s_mem !== 1'b0) begin n_fail++; $display("FAIL load_arb_cycle got s_mem=%b exp 0", s_mem); end
        step();  // grant cycle 1
        n_checks++; if ({s_mem, s_write, s_addr, s_sel} !== {1'b1, 1'b0, 30'h0000100, 4'hF}) begin n_fail++; $display("FAIL load_route got %h exp %h", {s_mem, s_write, s_addr, s_sel}, {1'b1, 1'b0, 30'h0000100, 4'hF}); end
        n_checks++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL load_early_ack got %b exp 0", m0_ack); end
        step();  // grant cycle 2: the slave acks
        s_ack = 1'b1; s_data_in = 32'h12345678;
        #1;
        n_checks++; if ({m0_ack, m0_err, m1_ack} !== 3'b100) begin n_fail++; $display("FAIL load_ack got %b exp 100", {m0_ack, m0_err, m1_ack}); end
        n_checks++; if (m0_data_in !== 32'h12345678) begin n_fail++; $display("FAIL load_data got %h exp 12345678", m0_data_in); end
        step();
        m0_mem = 1'b0; s_ack = 1'b0;
        #1;
        n_checks++; if ({s_mem, m0_ack} !== 2'b00) begin n_fail++; $display("FAIL load_idle got %b exp 00", {s_mem, m0_ack}); end
    endtask

    task automatic test_back_to_back();
        test_reset();
        m0_mem = 1'b1; m0_addr = 30'h0000AAA; m0_write = 1'b0;
        m1_mem = 1'b1; m1_addr = 30'h0000BBB; m1_write = 1'b1; m1_data_out = 32'hCAFEF00D;
        step();  // m0 granted: after reset, m0 wins the tie
        s_ack = 1'b1;
        #1;
        n_checks++; if (s_addr !== 30'h0000AAA) begin n_fail++; $display("FAIL b2b_first_addr got %h exp 0000aaa", s_addr); end
        n_checks++; if ({m0_ack, m1_ack} !== 2'b10) begin n_fail++; $display("FAIL b2b_first_ack got %b exp 10", {m0_ack, m1_ack}); end
        step();
        m0_mem = 1'b0;
        #1;
        n_checks++; if ({s_mem, s_write, s_addr, s_data_out} !== {1'b1, 1'b1, 30'h0000BBB, 32'hCAFEF00D}) begin n_fail++; $display("FAIL b2b_second_route got %h exp %h", {s_mem, s_write, s_addr, s_data_out}, {1'b1, 1'b1, 30'h0000BBB, 32'hCAFEF00D}); end
        n_checks++; if ({m0_ack, m1_ack} !== 2'b01) begin n_fail++; $display("FAIL b2b_second_ack got %b exp 01", {m0_ack, m1_ack}); end
        step();
        m1_mem = 1'b0; s_ack = 1'b0;
        #1;
        n_checks++; if (s_mem !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b exp 0", s_mem); end
    endtask

    task automatic test_round_robin();
        // m1 was served last, so m0 goes first.
        m0_mem = 1'b1; m1_mem = 1'b1;
        step();
        s_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if ({m0_ack, m1_ack} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_order[%0d] got %b exp %b", i, {m0_ack, m1_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            step();
        end
        // Now granted to m0 again; drop everything so the grant aborts back to idle.
        m0_mem = 1'b0; m1_mem = 1'b0; s_ack = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        m1_mem = 1'b1; m1_write = 1'b1; m1_addr = 30'h0000040; m1_data_out = 32'hDEADBEEF;
        step();  // grant cycle 1
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (m1_ack !== 1'b0) begin n_fail++; $display("FAIL to_no_ack[%0d] got %b exp 0", k, m1_ack); end
            step();
        end
        // Grant cycle 5: the counter reaches 4 and the error ack is forced.
        n_checks++; if ({m1_ack, m1_err, m0_ack} !== 3'b110) begin n_fail++; $display("FAIL to_err_ack got %b exp 110", {m1_ack, m1_err, m0_ack}); end
        step();
        m1_mem = 1'b0;
        #1;
        n_checks++; if (s_mem !== 1'b0) begin n_fail++; $display("FAIL to_idle got %b exp 0", s_mem); end
        m0_mem = 1'b1; m0_addr = 30'h0000200;
        step();
        s_ack = 1'b1;
        #1;
        n_checks++; if ({m0_ack, m0_err} !== 2'b10) begin n_fail++; $display("FAIL to_next_ok got %b exp 10", {m0_ack, m0_err}); end
        step();
        m0_mem = 1'b0; s_ack = 1'b0;
        step();
    endtask

    task automatic test_ack_at_timeout();
        m0_mem = 1'b1;
        step();  // grant cycle 1
        step(); step(); step(); step();  // grant cycle 5: the counter equals 4
        s_ack = 1'b1;
        #1;
        n_checks++; if ({m0_ack, m0_err} !== 2'b10) begin n_fail++; $display("FAIL ack_wins got %b exp 10", {m0_ack, m0_err}); end
        step();
        m0_mem = 1'b0; s_ack = 1'b0;
        step();
    endtask

    task automatic test_abort_and_reset();
        // m0 was served last. m1 requests and then aborts; last must stay unchanged.
        m1_mem = 1'b1; m1_addr = 30'h0000300;
        step();
        n_checks++; if (s_mem !== 1'b1) begin n_fail++; $display("FAIL abort_grant got %b exp 1", s_mem); end
        m1_mem = 1'b0;
        #1;
        n_checks++; if ({s_mem, m1_ack, m1_err} !== 3'b000) begin n_fail++; $display("FAIL abort_drop got %b exp 000", {s_mem, m1_ack, m1_err}); end
        step();
        // On a tie, m1 must win because m0 is still the last master served.
        m0_mem = 1'b1; m0_addr = 30'h0000111; m1_mem = 1'b1; m1_addr = 30'h0000222;
        step();
        n_checks++; if (s_addr !== 30'h0000222) begin n_fail++; $display("FAIL abort_last got %h exp 0000222", s_addr); end
        s_ack = 1'b1;
        step();  // m0 is granted back-to-back
        m1_mem = 1'b0;
        step();  // m0 acked, so it becomes last; the grant returns to idle
        s_ack = 1'b0;
        step();  // m0 is still requesting, so it is granted again
        n_checks++; if (s_addr !== 30'h0000111) begin n_fail++; $display("FAIL rst_pre_grant got %h exp 0000111", s_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({s_mem, m0_ack, m1_ack} !== 3'b000) begin n_fail++; $display("FAIL rst_async got %b exp 000", {s_mem, m0_ack, m1_ack}); end
        step();
        rst_n = 1'b1;
        m1_mem = 1'b1;
        step();
        n_checks++; if (s_addr !== 30'h0000111) begin n_fail++; $display("FAIL rst_tie_m0 got %h exp 0000111", s_addr); end
        m0_mem = 1'b0; m1_mem = 1'b0;
        step();
    endtask

    // Run each scenario in sequence, then print the summary.
    initial begin
        test_reset();
        test_single_load();
        test_back_to_back();
        test_round_robin();
        test_timeout();
        test_ack_at_timeout();
        test_abort_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
